// File: rtl/data_writeback_fill_controller_pkg.sv
// Shared cache definitions: write-back/fill FSM states and block geometry.
package cache_pkg;

    localparam int TAGBITS      = 14;
    localparam int BLOCKSIZE    = 4;
    localparam int WORD_BITS    = 32;
    localparam int BLOCK_OFFSET = $clog2(BLOCKSIZE);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        WRITE,
        DONE
    } wbfill_state_t;

endpackage

// File: rtl/data_writeback_fill_controller_if.sv
// Cache-array and memory-bus signals of the write-back/fill engine.
// master = the controller, slave = the cache array plus memory side.
interface data_writeback_fill_controller_if #(
    parameter int tagbits   = cache_pkg::TAGBITS,
    parameter int blocksize = cache_pkg::BLOCKSIZE
);
    import cache_pkg::*;

    logic                           Req;
    logic [31:0]                    ReqAddr;
    logic                           RV;
    logic                           Dirty;
    logic [tagbits-1:0]             RTag;
    logic [blocksize*WORD_BITS-1:0] RD;

    logic                           CacheWE;
    logic [31:0]                    CacheAddr;
    logic [WORD_BITS-1:0]           CacheWD;
    logic                           CacheDirty;
    logic                           Busy;
    logic                           Done;

    logic                           MemReq;
    logic                           MemWrite;
    logic [31:0]                    MemAddr;
    logic [WORD_BITS-1:0]           MemWD;
    logic [WORD_BITS-1:0]           MemRD;
    logic                           MemAck;

    modport master (
        input  Req, ReqAddr, RV, Dirty, RTag, RD, MemRD, MemAck,
        output CacheWE, CacheAddr, CacheWD, CacheDirty, Busy, Done,
               MemReq, MemWrite, MemAddr, MemWD
    );

    modport slave (
        output Req, ReqAddr, RV, Dirty, RTag, RD, MemRD, MemAck,
        input  CacheWE, CacheAddr, CacheWD, CacheDirty, Busy, Done,
               MemReq, MemWrite, MemAddr, MemWD
    );

endinterface

// File: rtl/data_writeback_fill_controller.sv
// Write-back data cache miss engine: evicts a dirty victim, then fills the block word by word.
// Optional DWB_CRITICAL_WORD_FIRST_EN starts the fill at the missing word and wraps.
//
// state | meaning
// IDLE  | waiting for a miss request
// WB    | writing victim words 0..blocksize-1 back to memory
// FILL  | reading one fill word (one idle cycle, then MemReq until MemAck)
// WRITE | one-cycle cache write of the fetched word
// DONE  | one-cycle completion pulse, still busy
module data_writeback_fill_controller
    import cache_pkg::*;
#(
    parameter int tagbits   = TAGBITS,
    parameter int blocksize = BLOCKSIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    data_writeback_fill_controller_if.master  bus
);

    localparam int OFF = $clog2(blocksize);
    localparam logic [OFF-1:0] LAST_WORD = OFF'(blocksize - 1);

`ifdef DWB_CRITICAL_WORD_FIRST_EN
    localparam bit CRIT_WORD_FIRST = 1'b1;
`else
    localparam bit CRIT_WORD_FIRST = 1'b0;
`endif

    function automatic logic [OFF-1:0] fill_start(input logic [31:0] a);
        return CRIT_WORD_FIRST ? a[OFF+1:2] : '0;
    endfunction

    wbfill_state_t                  state_q, state_d;
    logic [OFF-1:0]                 cnt_q, cnt_d;
    logic [OFF-1:0]                 fill_cnt_q, fill_cnt_d;
    logic [31:0]                    addr_q, addr_d;
    logic [tagbits-1:0]             tag_q, tag_d;
    logic [blocksize*WORD_BITS-1:0] victim_q, victim_d;

    logic                           cache_we_q, cache_we_d;
    logic [31:0]                    cache_addr_q, cache_addr_d;
    logic [WORD_BITS-1:0]           cache_wd_q, cache_wd_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           mem_req_q, mem_req_d;
    logic                           mem_write_q, mem_write_d;
    logic [31:0]                    mem_addr_q, mem_addr_d;
    logic [WORD_BITS-1:0]           mem_wd_q, mem_wd_d;

    logic                           ack;

    // An acknowledge only counts while a beat is actually being requested.
    assign ack = bus.MemAck & mem_req_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_cnt_d = fill_cnt_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        victim_d   = victim_q;

        case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    addr_d     = bus.ReqAddr;
                    tag_d      = bus.RTag;
                    victim_d   = bus.RD;
                    fill_cnt_d = '0;
                    if (bus.RV && bus.Dirty) begin
                        state_d = WB;
                        cnt_d   = '0;
                    end else begin
                        state_d = FILL;
                        cnt_d   = fill_start(bus.ReqAddr);
                    end
                end
            end
            WB: begin
                if (ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = FILL;
                        cnt_d   = fill_start(addr_q);
                    end
                end
            end
            FILL: begin
                if (ack) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d      = cnt_q + 1'b1;
                fill_cnt_d = fill_cnt_q + 1'b1;
                state_d    = (fill_cnt_q == LAST_WORD) ? DONE : FILL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered and describe the state being entered.
        cache_we_d   = 1'b0;
        cache_addr_d = '0;
        cache_wd_d   = '0;
        mem_req_d    = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wd_d     = '0;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);

        case (state_d)
            WB: begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b1;
                mem_addr_d  = {tag_d, addr_d[31-tagbits:OFF+2], cnt_d, 2'b00};
                mem_wd_d    = victim_d[int'(cnt_d)*WORD_BITS +: WORD_BITS];
            end
            FILL: begin
                // First FILL cycle leaves the bus idle between beats.
                mem_req_d  = (state_q == FILL);
                mem_addr_d = {addr_d[31:OFF+2], cnt_d, 2'b00};
            end
            WRITE: begin
                cache_we_d   = 1'b1;
                cache_addr_d = {addr_d[31:OFF+2], cnt_d, 2'b00};
                cache_wd_d   = bus.MemRD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fill_cnt_q   <= '0;
            addr_q       <= '0;
            tag_q        <= '0;
            victim_q     <= '0;
            cache_we_q   <= 1'b0;
            cache_addr_q <= '0;
            cache_wd_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            victim_q     <= victim_d;
            cache_we_q   <= cache_we_d;
            cache_addr_q <= cache_addr_d;
            cache_wd_q   <= cache_wd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
        end
    end

    assign bus.CacheWE    = cache_we_q;
    assign bus.CacheAddr  = cache_addr_q;
    assign bus.CacheWD    = cache_wd_q;
    assign bus.CacheDirty = 1'b0;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.MemReq     = mem_req_q;
    assign bus.MemWrite   = mem_write_q;
    assign bus.MemAddr    = mem_addr_q;
    assign bus.MemWD      = mem_wd_q;

endmodule
